// File: rtl/counter_pkg.sv
// Package: counter_pkg
//
// Types and constants shared by the direction debouncer and the 2-bit up/down
// counter stage it feeds.
//  - dir_t / DIR_UP / DIR_DOWN : direction encoding on the counter data_in
//  - deb_state_t               : debouncer qualification FSM states
package counter_pkg;

  typedef logic dir_t;

  localparam dir_t DIR_UP   = 1'b0;
  localparam dir_t DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } deb_state_t;

endpackage : counter_pkg

// File: rtl/direction_debouncer_if.sv
// Interface: direction_debouncer_if
//
// Bundles the raw switch input with the debounced direction outputs.
//  switch_in : raw, asynchronous, bouncing switch level
//  dir_out   : debounced direction level (0 = up, 1 = down)
//  dir_rise  : one-cycle pulse on dir_out 0->1
//  dir_fall  : one-cycle pulse on dir_out 1->0
//  bouncing  : high while a candidate change is being qualified
// Modports: master drives switch_in and observes the rest; slave is the debouncer.
interface direction_debouncer_if;
  import counter_pkg::*;

  logic switch_in;
  dir_t dir_out;
  logic dir_rise;
  logic dir_fall;
  logic bouncing;

  modport master (
    output switch_in,
    input  dir_out,
    input  dir_rise,
    input  dir_fall,
    input  bouncing
  );

  modport slave (
    input  switch_in,
    output dir_out,
    output dir_rise,
    output dir_fall,
    output bouncing
  );

endinterface : direction_debouncer_if

// File: rtl/direction_debouncer_sync_chain.sv
// Module: sync_chain
//
// Generic multi-flop synchronizer for an asynchronous single-bit input.
//  clk   : destination clock
//  reset : synchronous, active-high; clears every stage to 0
//  d     : asynchronous input
//  q     : synchronized output (last stage)
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("sync_chain: STAGES must be >= 2");
    end
  endgenerate

  logic [STAGES-1:0] stages_r;

  // Shift d through the chain; stage 0 is the metastability-catching flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      stages_r <= {STAGES{1'b0}};
    end else begin
      stages_r <= {stages_r[STAGES-2:0], d};
    end
  end

  assign q = stages_r[STAGES-1];

endmodule : sync_chain

// File: rtl/direction_debouncer.sv
// Module: direction_debouncer
//
// Turns the raw direction switch into a clean clk-synchronous level for the
// counter's data_in, plus change pulses and a bouncing status flag.
//  clk   : system clock
//  reset : synchronous, active-high; returns to STABLE_LO with all outputs 0
//  bus   : direction_debouncer_if.slave (switch_in in; dir_out, dir_rise,
//          dir_fall, bouncing out -- all outputs registered)
// A change is accepted only after the synchronized input has held its new
// value for DEBOUNCE_CYCLES consecutive cycles; any reversal during the
// window aborts back to the previous stable state.
module direction_debouncer
  import counter_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  direction_debouncer_if.slave  bus
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("direction_debouncer: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
      $error("direction_debouncer: DEBOUNCE_CYCLES must be >= 1");
    end
  endgenerate

  logic             sync_q_s;
  deb_state_t       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  dir_t             dir_r, dir_s;
  logic             rise_r, rise_s;
  logic             fall_r, fall_s;
  logic             bouncing_r, bouncing_s;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.switch_in),
    .q     (sync_q_s)
  );

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= STABLE_LO;
      cnt_r      <= CNT_ZERO;
      dir_r      <= DIR_UP;
      rise_r     <= 1'b0;
      fall_r     <= 1'b0;
      bouncing_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      dir_r      <= dir_s;
      rise_r     <= rise_s;
      fall_r     <= fall_s;
      bouncing_r <= bouncing_s;
    end
  end

  // Next-state, counter and next-output logic of the qualification FSM.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    dir_s   = dir_r;
    rise_s  = 1'b0;
    fall_s  = 1'b0;

    case (state_r)
      STABLE_LO: begin
        if (sync_q_s) begin
          state_s = WAIT_HI;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = STABLE_LO;
        end
      end

      WAIT_HI: begin
        if (!sync_q_s) begin
          state_s = STABLE_LO;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_MAX) begin
          state_s = STABLE_HI;
          cnt_s   = CNT_ZERO;
          dir_s   = DIR_DOWN;
          rise_s  = 1'b1;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end

      STABLE_HI: begin
        if (!sync_q_s) begin
          state_s = WAIT_LO;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = STABLE_HI;
        end
      end

      WAIT_LO: begin
        if (sync_q_s) begin
          state_s = STABLE_HI;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_MAX) begin
          state_s = STABLE_LO;
          cnt_s   = CNT_ZERO;
          dir_s   = DIR_UP;
          fall_s  = 1'b1;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end

      default: begin
        state_s = STABLE_LO;
        cnt_s   = CNT_ZERO;
        dir_s   = DIR_UP;
      end
    endcase

    // Registered alongside state so the flag tracks the WAIT states exactly.
    bouncing_s = (state_s == WAIT_HI) || (state_s == WAIT_LO);
  end

  assign bus.dir_out  = dir_r;
  assign bus.dir_rise = rise_r;
  assign bus.dir_fall = fall_r;
  assign bus.bouncing = bouncing_r;

endmodule : direction_debouncer

// File: tb/tb_direction_debouncer.sv
// Testbench: tb_direction_debouncer
//
// Directed sequence with SYNC_STAGES=2, DEBOUNCE_CYCLES=4. Each step drives
// switch_in/reset before a rising edge and pushes the expected output vector
// {dir_out, dir_rise, dir_fall, bouncing} for that edge; after the edge the
// entry is popped and compared with the DUT outputs.
module tb_direction_debouncer;
  import counter_pkg::*;

  typedef struct {
    string      tag;
    logic [3:0] exp;
  } sb_entry_t;

  logic clk;
  logic reset;
  int   n_asserts;
  int   n_fails;
  int   rise_count;
  sb_entry_t sb_q[$];

  direction_debouncer_if dif ();

  direction_debouncer #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, queue its expectation, then check after the edge.
  task automatic step(input logic sw, input logic rst, input logic [3:0] exp, input string tag);
    sb_entry_t e;
    logic [3:0] obs;
    @(negedge clk);
    dif.switch_in = sw;
    reset         = rst;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e   = sb_q.pop_front();
    obs = {dif.dir_out, dif.dir_rise, dif.dir_fall, dif.bouncing};
    if (dif.dir_rise === 1'b1) rise_count++;
    n_asserts++;
    assert (obs === e.exp) else begin
      n_fails++;
      $error("FAIL %s observed={dir,rise,fall,bnc}=%b expected=%b", e.tag, obs, e.exp);
    end
  endtask

  initial begin
    n_asserts     = 0;
    n_fails       = 0;
    rise_count    = 0;
    reset         = 1'b1;
    dif.switch_in = 1'b1;

    // 1. Reset held 3 cycles with switch high, then one cycle after release.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'b0000, "reset_hold");
    step(1'b0, 1'b0, 4'b0000, "reset_release");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b0000, "idle_lo");

    // 3. Glitch: 3 cycles high is shorter than the window.
    step(1'b1, 1'b0, 4'b0000, "glitch_s0");
    step(1'b1, 1'b0, 4'b0000, "glitch_s1");
    step(1'b1, 1'b0, 4'b0001, "glitch_s2");
    step(1'b0, 1'b0, 4'b0001, "glitch_s3");
    step(1'b0, 1'b0, 4'b0001, "glitch_s4");
    step(1'b0, 1'b0, 4'b0000, "glitch_s5");
    step(1'b0, 1'b0, 4'b0000, "glitch_s6");

    // 2. Clean rise: accepted at s+6, pulse gone at s+7.
    step(1'b1, 1'b0, 4'b0000, "rise_s0");
    step(1'b1, 1'b0, 4'b0000, "rise_s1");
    for (int i = 2; i < 6; i++) step(1'b1, 1'b0, 4'b0001, "rise_wait");
    step(1'b1, 1'b0, 4'b1100, "rise_s6");
    step(1'b1, 1'b0, 4'b1000, "rise_s7");

    // 4. Clean fall from dir_out=1.
    step(1'b0, 1'b0, 4'b1000, "fall_s0");
    step(1'b0, 1'b0, 4'b1000, "fall_s1");
    for (int i = 2; i < 6; i++) step(1'b0, 1'b0, 4'b1001, "fall_wait");
    step(1'b0, 1'b0, 4'b0010, "fall_s6");
    step(1'b0, 1'b0, 4'b0000, "fall_s7");

    // Back to dir_out=1 for the reset-abort case.
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 4'b0000, "rerise_sync");
    for (int i = 2; i < 6; i++) step(1'b1, 1'b0, 4'b0001, "rerise_wait");
    step(1'b1, 1'b0, 4'b1100, "rerise_s6");
    step(1'b1, 1'b0, 4'b1000, "rerise_s7");

    // 5. Reset while qualifying a fall in WAIT_LO.
    step(1'b0, 1'b0, 4'b1000, "midrst_s0");
    step(1'b0, 1'b0, 4'b1000, "midrst_s1");
    step(1'b0, 1'b0, 4'b1001, "midrst_s2");
    step(1'b0, 1'b0, 4'b1001, "midrst_s3");
    step(1'b0, 1'b1, 4'b0000, "midrst_reset");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'b0000, "midrst_after");

    // 6. Bounce burst: 20 toggles starting high, then held high.
    rise_count = 0;
    begin
      logic sw_hist [0:29];
      logic [3:0] exp_v;
      for (int i = 0; i < 30; i++) begin
        sw_hist[i] = (i < 20) ? ((i % 2) == 0) : 1'b1;
        if (i < 26) exp_v = {3'b000, (i >= 2) ? sw_hist[i-2] : 1'b0};
        else if (i == 26) exp_v = 4'b1100;
        else exp_v = 4'b1000;
        step(sw_hist[i], 1'b0, exp_v, "burst");
      end
    end
    n_asserts++;
    assert (rise_count == 1) else begin
      n_fails++;
      $error("FAIL burst_rise_count observed=%0d expected=1", rise_count);
    end

    n_asserts++;
    assert (sb_q.size() == 0) else begin
      n_fails++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule : tb_direction_debouncer
